// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the serial transmitter and its bit-period strobe.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Bit counter must be able to represent WIDTH itself.
  function automatic int bit_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int div_cnt_w(input int div);
    return $clog2(div) + 1;
  endfunction

endpackage

// File: rtl/bit_tick_gen.sv
// DIV-cycle strobe: tick is high in the last cycle of every DIV-cycle period while enabled.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int              CW   = div_cnt_w(DIV);
  localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  // With DIV=1 the count never leaves zero, so every enabled cycle is a tick.
  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_shift_tx.sv
// Parallel-in serial-out transmitter: accepts a word on valid/ready and shifts it
// out on sdo, one bit per DIV clocks, with a frame strobe and an end-of-word pulse.
module piso_shift_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int DIV        = 4,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdo,
  output logic             frame,
  output logic             done
);

  localparam int            BW       = bit_cnt_w(WIDTH);
  localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_shifted;
  logic [BW-1:0]    bit_cnt;
  logic             accept, tick, last_tick, shifting;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
  assign shifting     = (state == SHIFT);

  bit_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept),
    .en   (shifting),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // din_ready and frame depend only on state, never on din_valid.
  always_comb begin
    state_nxt = state;
    din_ready = 1'b0;
    frame     = 1'b0;
    accept    = 1'b0;
    last_tick = 1'b0;
    case (state)
      IDLE: begin
        din_ready = 1'b1;
        if (din_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        frame = 1'b1;
        if (tick && (bit_cnt == LAST_BIT)) begin
          last_tick = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg    <= '0;
      bit_cnt <= '0;
      sdo     <= IDLE_LEVEL;
      done    <= 1'b0;
    end else begin
      done <= last_tick;
      if (accept) begin
        sreg    <= din;
        bit_cnt <= '0;
        sdo     <= head(din);
      end else if (last_tick) begin
        bit_cnt <= '0;
        sdo     <= IDLE_LEVEL;
      end else if (tick) begin
        sreg    <= sreg_shifted;
        bit_cnt <= bit_cnt + 1'b1;
        sdo     <= head(sreg_shifted);
      end
    end
  end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Scoreboard bench for piso_shift_tx: three configurations driven in parallel, every
// accepted word queued with its handshake edge and checked cycle by cycle on the serial side.
module tb_piso_shift_tx;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] din       [3];
  logic         din_valid [3];
  logic         din_ready [3];
  logic         sdo       [3];
  logic         frame     [3];
  logic         done      [3];

  always #5 clk = ~clk;

  piso_shift_tx #(.WIDTH(W), .DIV(4), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u0 (
    .clk(clk), .rst(rst), .din(din[0]), .din_valid(din_valid[0]),
    .din_ready(din_ready[0]), .sdo(sdo[0]), .frame(frame[0]), .done(done[0]));

  piso_shift_tx #(.WIDTH(W), .DIV(2), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u1 (
    .clk(clk), .rst(rst), .din(din[1]), .din_valid(din_valid[1]),
    .din_ready(din_ready[1]), .sdo(sdo[1]), .frame(frame[1]), .done(done[1]));

  piso_shift_tx #(.WIDTH(W), .DIV(1), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u2 (
    .clk(clk), .rst(rst), .din(din[2]), .din_valid(din_valid[2]),
    .din_ready(din_ready[2]), .sdo(sdo[2]), .frame(frame[2]), .done(done[2]));

  function automatic int div_of(input int g);
    case (g)
      0:       return 4;
      1:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic bit msb_of(input int g);
    return (g != 1);
  endfunction

  function automatic logic idle_of(input int g);
    return (g != 1);
  endfunction

  // k-th transmitted bit of a word, straight from the transmit order.
  function automatic logic exp_bit(input int g, input logic [W-1:0] w, input int k);
    return msb_of(g) ? w[W-1-k] : w[k];
  endfunction

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int acc_cnt  [3] = '{0, 0, 0};
  int acc_edge [3] = '{0, 0, 0};

  logic [W-1:0] wq [3][$];
  int           nq [3][$];
  bit           active [3] = '{0, 0, 0};
  logic [W-1:0] cur_w  [3];
  int           cur_n  [3];

  task automatic check(input string name, input int g, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s u%0d cyc=%0d: got %0h expected %0h", name, g, cyc, act, exp);
  endtask

  // Handshake detector: the word and edge index become the expectation.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < 3; g++) begin
      if (!rst && din_valid[g] && din_ready[g]) begin
        wq[g].push_back(din[g]);
        nq[g].push_back(cyc + 1);
        acc_cnt[g]  <= acc_cnt[g] + 1;
        acc_edge[g] <= cyc + 1;
      end
    end
  end

  // Monitor: pops an expected word when one is pending and checks every cycle.
  always @(negedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (rst) begin
        active[g] = 1'b0;
        wq[g].delete();
        nq[g].delete();
        check("rst_frame", g, frame[g], 1'b0);
        check("rst_ready", g, din_ready[g], 1'b1);
        check("rst_sdo", g, sdo[g], idle_of(g));
        check("rst_done", g, done[g], 1'b0);
      end else begin
        if (!active[g] && wq[g].size() > 0) begin
          active[g] = 1'b1;
          cur_w[g]  = wq[g].pop_front();
          cur_n[g]  = nq[g].pop_front();
        end
        if (active[g]) begin
          int off;
          off = cyc - cur_n[g];
          if (off < W * div_of(g)) begin
            check("frame_busy", g, frame[g], 1'b1);
            check("ready_busy", g, din_ready[g], 1'b0);
            check("done_busy", g, done[g], 1'b0);
            check("sdo_bit", g, sdo[g], exp_bit(g, cur_w[g], off / div_of(g)));
          end else begin
            check("done_pulse", g, done[g], 1'b1);
            check("frame_end", g, frame[g], 1'b0);
            check("ready_end", g, din_ready[g], 1'b1);
            check("sdo_end", g, sdo[g], idle_of(g));
            active[g] = 1'b0;
          end
        end else begin
          check("idle_frame", g, frame[g], 1'b0);
          check("idle_ready", g, din_ready[g], 1'b1);
          check("idle_done", g, done[g], 1'b0);
          check("idle_sdo", g, sdo[g], idle_of(g));
        end
      end
    end
  end

  task automatic send(input int g, input logic [W-1:0] w, input bit keep, output int edge_n);
    int start;
    bit ok;
    ok           = 1'b0;
    din[g]       = w;
    din_valid[g] = 1'b1;
    start        = acc_cnt[g];
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #2;
      if (acc_cnt[g] != start) begin
        ok = 1'b1;
        break;
      end
    end
    check("accept", g, ok, 1'b1);
    edge_n = acc_edge[g];
    if (!keep) din_valid[g] = 1'b0;
  endtask

  task automatic rand_send(input int g);
    int e, gap;
    logic [W-1:0] w;
    w   = W'($urandom);
    gap = $urandom_range(0, 3);
    repeat (gap) begin @(posedge clk); #2; end
    send(g, w, 1'($urandom_range(0, 1)), e);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int g = 0; g < 3; g++) din_valid[g] = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #2;
      if (!active[0] && !active[1] && !active[2] &&
          wq[0].size() == 0 && wq[1].size() == 0 && wq[2].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    check("drain", 0, ok, 1'b1);
  endtask

  int e0, e1a, e2a, e2b;

  initial begin
    for (int g = 0; g < 3; g++) begin
      din[g]       = '0;
      din_valid[g] = 1'b0;
    end
    #1 rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      check("por_ready", g, din_ready[g], 1'b1);
      check("por_sdo", g, sdo[g], idle_of(g));
      check("por_frame", g, frame[g], 1'b0);
      check("por_done", g, done[g], 1'b0);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 0xA5 MSB-first /4, 0x01 LSB-first /2, and back-to-back 0xFF,0x00 at /1
    fork
      send(0, 8'hA5, 1'b0, e0);
      send(1, 8'h01, 1'b0, e1a);
      begin
        send(2, 8'hFF, 1'b1, e2a);
        send(2, 8'h00, 1'b0, e2b);
      end
    join
    check("b2b_gap", 2, e2b - e2a, W + 1);
    wait_idle();

    // Scribble on din/din_valid while 0x3C is in flight
    send(0, 8'h3C, 1'b0, e0);
    din[0] = 8'hFF;
    repeat (W * 4 - 6) begin
      @(posedge clk); #2;
      din[0]       = W'($urandom);
      din_valid[0] = 1'($urandom_range(0, 1));
    end
    din_valid[0] = 1'b0;
    wait_idle();

    // Asynchronous reset in the middle of bit 3 of 0xA5
    send(0, 8'hA5, 1'b0, e0);
    repeat (13) @(posedge clk);
    #2;
    check("pre_rst_frame", 0, frame[0], 1'b1);
    rst = 1'b1;
    #1;
    check("async_frame", 0, frame[0], 1'b0);
    check("async_ready", 0, din_ready[0], 1'b1);
    check("async_sdo", 0, sdo[0], 1'b1);
    check("async_done", 0, done[0], 1'b0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    send(0, 8'h5A, 1'b0, e0);
    wait_idle();

    // Quiet period after reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (50) @(posedge clk);
    #2;

    repeat (30) begin
      fork
        rand_send(0);
        rand_send(1);
        rand_send(2);
      join
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
